// File: rtl/stopwatch_ctrl.sv
// Run-control sequencer for the stopwatch counter: button edge detect, run FSM, step prescaler.
// Optional lap hold of the displayed value is enabled by defining STOPWATCH_CTRL_LAP_EN.
module stopwatch_ctrl #(
  parameter int unsigned WIDTH     = 15,
  parameter int unsigned MAX_COUNT = 9999,
  parameter int unsigned FREQ_BITS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef STOPWATCH_CTRL_LAP_EN
  input  logic                 btn_lap,
`endif
  input  logic                 btn_clear,
  input  logic                 btn_stop,
  input  logic                 btn_up,
  input  logic                 btn_down,
  input  logic [FREQ_BITS-1:0] frequency,
  input  logic [WIDTH-1:0]     count,
  output logic                 step,
  output logic signed [2:0]    diff,
  output logic                 clear,
  output logic [WIDTH-1:0]     display_value,
  output logic                 led_up,
  output logic                 led_down,
  output logic                 led_overflow,
  output logic [1:0]           state
);

  localparam int unsigned PRESC_W = 2 ** FREQ_BITS;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_UP   = 2'd1,
    RUN_DOWN = 2'd2,
    OVF      = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         btn_q, btn_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               step_q, step_d;
  logic               clear_q, clear_d;
  logic signed [2:0]  diff_q, diff_d;
  logic [WIDTH-1:0]   disp_q, disp_d;
  logic               led_up_q, led_up_d;
  logic               led_down_q, led_down_d;
  logic               led_ovf_q, led_ovf_d;

  logic [3:0]           press;
  logic                 ev_clear, ev_stop, ev_up, ev_down;
  logic                 running, tick, at_limit;
  logic [FREQ_BITS-1:0] exp_eff;
  logic [PRESC_W-1:0]   presc_max;

`ifdef STOPWATCH_CTRL_LAP_EN
  logic lap_q, lap_d;
  logic hold_q, hold_d;
  logic ev_lap;
`endif

  // Event decode with fixed priority clear > stop > up > down.
  always_comb begin
    btn_d    = {btn_clear, btn_stop, btn_up, btn_down};
    press    = btn_d & ~btn_q;
    ev_clear = press[3];
    ev_stop  = press[2] & ~press[3];
    ev_up    = press[1] & ~(|press[3:2]);
    ev_down  = press[0] & ~(|press[3:1]);
  end

  // Tick period is 2^max(frequency,1); >= keeps a shortened period from running away.
  always_comb begin
    exp_eff   = (frequency == '0) ? FREQ_BITS'(1) : frequency;
    presc_max = (PRESC_W'(1) << exp_eff) - PRESC_W'(1);
    running   = (state_q == RUN_UP) || (state_q == RUN_DOWN);
    tick      = running && (presc_q >= presc_max);
    at_limit  = ((state_q == RUN_UP) && (count == WIDTH'(MAX_COUNT))) ||
                ((state_q == RUN_DOWN) && (count == '0));
  end

  always_comb begin
    state_d    = state_q;
    step_d     = 1'b0;
    clear_d    = 1'b0;
    presc_d    = '0;
    diff_d     = 3'sd0;
    disp_d     = count;
    led_up_d   = 1'b0;
    led_down_d = 1'b0;
    led_ovf_d  = 1'b0;

    if (ev_clear) begin
      state_d = IDLE;
      clear_d = 1'b1;
    end else if (ev_stop) begin
      state_d = IDLE;
    end else if (ev_up) begin
      state_d = RUN_UP;
    end else if (ev_down) begin
      state_d = RUN_DOWN;
    end else if (tick) begin
      if (at_limit) state_d = OVF;
      else          step_d  = 1'b1;
    end

    // Prescaler restarts on any state change and idles outside the running states.
    if ((state_d == state_q) && running && !tick) presc_d = presc_q + PRESC_W'(1);

    case (state_d)
      RUN_UP:   diff_d = 3'sd1;
      RUN_DOWN: diff_d = -3'sd1;
      default:  diff_d = 3'sd0;
    endcase

    led_up_d   = (state_d == RUN_UP);
    led_down_d = (state_d == RUN_DOWN);
    led_ovf_d  = (state_d == OVF);
  end

`ifdef STOPWATCH_CTRL_LAP_EN
  // Lap toggles a display freeze; only taken when no higher-priority button fired.
  always_comb begin
    lap_d  = btn_lap;
    ev_lap = btn_lap & ~lap_q & ~(|press);
    hold_d = hold_q;
    if (ev_clear || ev_stop) hold_d = 1'b0;
    else if (ev_lap)         hold_d = ~hold_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      btn_q      <= '1;
      presc_q    <= '0;
      step_q     <= 1'b0;
      clear_q    <= 1'b0;
      diff_q     <= 3'sd0;
      disp_q     <= '0;
      led_up_q   <= 1'b0;
      led_down_q <= 1'b0;
      led_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      btn_q      <= btn_d;
      presc_q    <= presc_d;
      step_q     <= step_d;
      clear_q    <= clear_d;
      diff_q     <= diff_d;
`ifdef STOPWATCH_CTRL_LAP_EN
      disp_q     <= (hold_q && hold_d) ? disp_q : disp_d;
`else
      disp_q     <= disp_d;
`endif
      led_up_q   <= led_up_d;
      led_down_q <= led_down_d;
      led_ovf_q  <= led_ovf_d;
    end
  end

`ifdef STOPWATCH_CTRL_LAP_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      lap_q  <= 1'b1;
      hold_q <= 1'b0;
    end else begin
      lap_q  <= lap_d;
      hold_q <= hold_d;
    end
  end
`endif

  assign step          = step_q;
  assign diff          = diff_q;
  assign clear         = clear_q;
  assign display_value = disp_q;
  assign led_up        = led_up_q;
  assign led_down      = led_down_q;
  assign led_overflow  = led_ovf_q;
  assign state         = state_q;

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Run-control sequencer for the stopwatch counting datapath. Turns synchronized button levels into edge-triggered commands and runs a four-state FSM (idle, up, down, overflow). Issues one-cycle `step` pulses with a signed `diff` to the external 0..MAX_COUNT counter, at a rate set by `frequency`. Sits between the button synchronizers and the counter/display pair, and owns LED status and the value handed to the display.

## Interface
- `WIDTH`, 15: width of `count` and `display_value`.
- `MAX_COUNT`, 9999: upper bound of the counter; lower bound is fixed at 0.
- `FREQ_BITS`, 5: width of `frequency`.

- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `btn_clear`, `btn_stop`, `btn_up`, `btn_down`  in  1 each  already-synchronized button levels.
- `frequency`  in  FREQ_BITS  tick period exponent.
- `count`  in  WIDTH  current counter value, fed back from the datapath.
- `step`  out  1  one-cycle pulse; the counter adds `diff` on this cycle.
- `diff`  out  3, signed  +1 in RUN_UP, −1 in RUN_DOWN, 0 otherwise.
- `clear`  out  1  one-cycle pulse; the counter loads 0.
- `display_value`  out  WIDTH  value for the display block.
- `led_up`, `led_down`, `led_overflow`  out  1 each  status LEDs.
- `state`  out  2  IDLE=0, RUN_UP=1, RUN_DOWN=2, OVF=3.

## Operation
- **Edge detect:** each button has a registered copy `btn_q`. A press event is `btn & ~btn_q`. Reset sets every `btn_q` to 1, so a button held through reset is ignored until it is released.
- **Event priority:** one event is taken per cycle, in this order: clear > stop > up > down. Lower-priority events in the same cycle are discarded.
- **State transitions:**
  - clear from any state: go to IDLE, pulse `clear`, clear `led_overflow`.
  - stop: go to IDLE from any state and clear `led_overflow`. In IDLE it is a no-op.
  - up: go to RUN_UP from any state, including OVF, which clears `led_overflow`.
  - down: go to RUN_DOWN from any state, including OVF, which clears `led_overflow`.
  - up in RUN_UP and down in RUN_DOWN are no-ops; the prescaler is not restarted.
- **Prescaler:**
  - Counts only in RUN_UP and RUN_DOWN. It is cleared on every state change.
  - Tick period is P = 2^max(frequency,1) cycles. The minimum of 2 guarantees `count` has settled before the next boundary check.
  - A tick fires when the prescaler reaches P−1, and the prescaler then wraps to 0.
  - A change to `frequency` takes effect at the next comparison; the count is not restarted.
- **Tick handling:**
  - RUN_UP with `count`==MAX_COUNT: no step; go to OVF and set `led_overflow`.
  - RUN_DOWN with `count`==0: no step; go to OVF and set `led_overflow`.
  - Otherwise: pulse `step`.
  - If a tick and a button event occur in the same cycle, the event wins and the tick is dropped.
- **LEDs:** `led_up` = (state==RUN_UP) and `led_down` = (state==RUN_DOWN). In OVF both are 0.
- **Display:** `display_value` is a registered copy of `count`, one cycle of lag (unless lap hold is active; see Configuration).

## Timing
- All outputs are registered.
- An event sampled in cycle N updates `state`, the LEDs, `diff` and `clear` at N+1.
- A tick detected in cycle N produces `step` at N+1. The counter updates `count` at N+2.
- In a running state, `step` pulses are exactly P cycles apart.
- The first `step` after entering a running state at cycle N+1 appears at N+1+P.
- Reset values: `state`=IDLE, prescaler=0, all `btn_q`=1, `step`=0, `clear`=0, `diff`=0, `display_value`=0, all LEDs 0.
- `reset` does not pulse `clear`; the counter has its own reset.
- `reset` asserted mid-run forces IDLE on the next edge and aborts any pending `step`.

## Configuration
- **Macro:** `STOPWATCH_CTRL_LAP_EN`.
- **Defined:**
  - Adds input `btn_lap` (1 bit, edge-detected like the other buttons, lowest priority).
  - A lap event while `hold`=0 sets `hold`=1 and freezes `display_value` at the current `count`.
  - A lap event while `hold`=1 releases it.
  - `hold` is cleared by clear, stop and `reset`.
  - Counting and `step` are unaffected by `hold`.
- **Undefined:** no `btn_lap` port and no hold register; `display_value` always tracks `count`.

## Test plan
- **Up count, exact spacing:** frequency=2, pulse `btn_up` → `state`=1, `led_up`=1, `diff`=+1; `step` pulses every 4 cycles, first one 4 cycles after the state change.
- **Overflow at top:** `count` held at 9999 in RUN_UP, frequency=1 → at the next tick no `step`, `state`=3, `led_overflow`=1, `led_up`=0, `diff`=0.
- **Overflow at bottom, then recovery:** RUN_DOWN with `count`=0 → OVF. Then press `btn_up` → `state`=1, `led_overflow`=0, steps resume.
- **Simultaneous buttons:** `btn_clear` and `btn_up` rise in the same cycle → `state`=0, one-cycle `clear`, `diff`=0. A tick coinciding with `btn_stop` produces no `step`.
- **Reset behaviour:** assert `reset` mid-run with `btn_up` held through reset → all outputs 0 and IDLE; no RUN_UP until `btn_up` is released and pressed again.
- **Lap hold (`STOPWATCH_CTRL_LAP_EN`):** lap at `count`=42 while running → `display_value` stays 42 while steps continue; a second lap → `display_value` tracks `count` again.
